// File: rtl/pipelined_cpu.sv
// Three-stage (fetch, decode/read, execute/writeback) pipelined CPU with JMP, HLT and external stall.
// Define PIPELINED_CPU_FORWARD_EN to forward E results into D; otherwise distance-1 hazards interlock.
module pipelined_cpu #(
    parameter int DATA_W = 8,
    parameter int NREG   = 16,
    parameter int PC_W   = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_halt,
    output logic [PC_W-1:0]   o_pc,
    input  logic [15:0]       i_instruction,
    output logic              o_write_en,
    output logic [3:0]        o_write_addr,
    output logic [DATA_W-1:0] o_write_data,
    output logic              o_halted
);

    localparam int          SH_W   = $clog2(DATA_W);
    localparam logic [15:0] NOP_W  = 16'h0000;
    localparam logic [4:0]  NREG_L = 5'(NREG);

    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR  = 4'h4,
                           OP_XOR = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7, OP_LDI = 4'h8,
                           OP_MOV = 4'h9, OP_HLT = 4'hE, OP_JMP = 4'hF;

    typedef struct packed {
        logic              valid;
        logic [3:0]        op;
        logic [3:0]        dest;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [7:0]        imm;
    } de_t;

    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic              halt_flag;
    logic              rst_q;
    de_t               ex;
    logic [DATA_W-1:0] regs [NREG];

    logic [3:0]        d_op, d_dest, d_s1, d_s2;
    logic              d_writes, d_use1, d_use2;
    logic              m1, m2, stall;
    logic [DATA_W-1:0] rd1, rd2, op_a, op_b, alu;

    assign d_op     = ir[15:12];
    assign d_dest   = ir[11:8];
    assign d_s1     = ir[7:4];
    assign d_s2     = ir[3:0];
    assign d_writes = (d_op >= OP_ADD) && (d_op <= OP_MOV);
    assign d_use1   = d_writes && (d_op != OP_LDI);
    assign d_use2   = (d_op >= OP_ADD) && (d_op <= OP_SHR);

    // Indices at or above NREG read as zero
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < NREG; i++) begin
            if (d_s1 == 4'(i)) rd1 = regs[i];
            if (d_s2 == 4'(i)) rd2 = regs[i];
        end
    end

    always_comb begin
        alu = '0;
        case (ex.op)
            OP_ADD:  alu = ex.a + ex.b;
            OP_SUB:  alu = ex.a - ex.b;
            OP_AND:  alu = ex.a & ex.b;
            OP_OR:   alu = ex.a | ex.b;
            OP_XOR:  alu = ex.a ^ ex.b;
            OP_SHL:  alu = ex.a << ex.b[SH_W-1:0];
            OP_SHR:  alu = ex.a >> ex.b[SH_W-1:0];
            OP_LDI:  alu = DATA_W'(ex.imm);
            OP_MOV:  alu = ex.a;
            default: alu = '0;
        endcase
    end

    // A dropped write to an out-of-range register is not a real dependence
    assign m1 = ex.valid && d_use1 && (ex.dest == d_s1) && ({1'b0, d_s1} < NREG_L);
    assign m2 = ex.valid && d_use2 && (ex.dest == d_s2) && ({1'b0, d_s2} < NREG_L);

`ifdef PIPELINED_CPU_FORWARD_EN
    assign op_a  = m1 ? alu : rd1;
    assign op_b  = m2 ? alu : rd2;
    assign stall = 1'b0;
`else
    assign op_a  = rd1;
    assign op_b  = rd2;
    assign stall = m1 | m2;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc           <= '0;
            ir           <= NOP_W;
            halt_flag    <= 1'b0;
            rst_q        <= 1'b1;
            ex           <= '0;
            o_write_en   <= 1'b0;
            o_write_addr <= '0;
            o_write_data <= '0;
        end else begin
            rst_q      <= 1'b0;
            o_write_en <= ex.valid;
            if (ex.valid) begin
                o_write_addr <= ex.dest;
                o_write_data <= alu;
            end
            ex.valid <= 1'b0;
            if (i_halt) begin
                // hold PC and IR; bubble enters E
            end else if (halt_flag) begin
                ir <= NOP_W;
            end else if (d_op == OP_HLT) begin
                halt_flag <= 1'b1;
                ir        <= NOP_W;
            end else if (d_op == OP_JMP) begin
                pc <= ir[PC_W-1:0];
                ir <= NOP_W;
            end else if (!stall) begin
                pc <= pc + PC_W'(1);
                ir <= i_instruction;
                ex <= '{valid: d_writes, op: d_op, dest: d_dest, a: op_a, b: op_b, imm: ir[7:0]};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (i_reset)
                regs[i] <= '0;
            else if (ex.valid && ex.dest == 4'(i))
                regs[i] <= alu;
        end
    end

    assign o_pc     = pc;
    // Held low in the first cycle after reset even though E is empty
    assign o_halted = (i_halt | halt_flag) & ~ex.valid & ~rst_q;

endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed bench for pipelined_cpu (DATA_W=8, NREG=4): write trace, PC sequence and halt behaviour.
module tb_pipelined_cpu;
    localparam int DATA_W = 8;
    localparam int NREG   = 4;
    localparam int PC_W   = 12;
`ifdef PIPELINED_CPU_FORWARD_EN
    localparam int GAP = 0;
`else
    localparam int GAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hlt = 1'b0;
    logic [PC_W-1:0]   pc;
    logic [15:0]       instr;
    logic              we;
    logic [3:0]        wa;
    logic [DATA_W-1:0] wd;
    logic              halted;
    logic [15:0]       imem [4096];

    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t             wr_q[$];
    int              cyc;
    logic [PC_W-1:0] pc_log  [64];
    logic            hlt_log [64];
    int              n_chk = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;
    assign instr = imem[pc];

    pipelined_cpu #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W)) dut (
        .i_clk(clk), .i_reset(rst), .i_halt(hlt), .o_pc(pc), .i_instruction(instr),
        .o_write_en(we), .o_write_addr(wa), .o_write_data(wd), .o_halted(halted)
    );

    // cycle 0 is the first cycle after reset is released
    always @(negedge clk) begin
        if (rst) begin
            cyc <= 0;
            wr_q.delete();
        end else begin
            if (cyc < 64) begin
                pc_log[cyc]  <= pc;
                hlt_log[cyc] <= halted;
            end
            if (we) wr_q.push_back('{cyc, wa, wd});
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input int a, input int d);
        if (idx < wr_q.size()) begin
            chk($sformatf("%s[%0d].addr", tag, idx), 32'(wr_q[idx].a), 32'(a));
            chk($sformatf("%s[%0d].data", tag, idx), 32'(wr_q[idx].d), 32'(d));
        end else begin
            chk($sformatf("%s[%0d].present", tag, idx), 32'(wr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // basic LDI/ADD trace and PC sequence
        clr_mem();
        imem[0] = 16'h8105; imem[1] = 16'h8203; imem[3] = 16'h1312;
        do_reset();
        chk("rst_pc", 32'(pc), 0);
        repeat (12) @(posedge clk); #1;
        chk("a_pc0", 32'(pc_log[0]), 0);
        chk("a_pc1", 32'(pc_log[1]), 1);
        chk("a_pc2", 32'(pc_log[2]), 2);
        chk("a_pc3", 32'(pc_log[3]), 3);
        chk("a_nwr", 32'(wr_q.size()), 3);
        chk_wr("a_wr", 0, 1, 5);
        chk_wr("a_wr", 1, 2, 3);
        chk_wr("a_wr", 2, 3, 8);
        if (wr_q.size() > 0) chk("a_wr0_cyc", 32'(wr_q[0].cyc), 3);

        // distance-1 dependence
        clr_mem();
        imem[0] = 16'h8107; imem[1] = 16'h1211;
        do_reset();
        repeat (10) @(posedge clk); #1;
        chk("b_nwr", 32'(wr_q.size()), 2);
        chk_wr("b_wr", 0, 1, 7);
        chk_wr("b_wr", 1, 2, 14);
        if (wr_q.size() == 2) begin
            chk("b_cyc0", 32'(wr_q[0].cyc), 3);
            chk("b_gap", 32'(wr_q[1].cyc - wr_q[0].cyc - 1), 32'(GAP));
        end

        // jump flushes the word after it
        clr_mem();
        imem[0] = 16'h8101; imem[2] = 16'hF010; imem[3] = 16'h8209; imem[16] = 16'h8303;
        do_reset();
        repeat (12) @(posedge clk); #1;
        chk("c_pc2", 32'(pc_log[2]), 2);
        chk("c_pc3", 32'(pc_log[3]), 3);
        chk("c_pc4", 32'(pc_log[4]), 16);
        chk("c_pc5", 32'(pc_log[5]), 17);
        chk("c_nwr", 32'(wr_q.size()), 2);
        chk_wr("c_wr", 0, 1, 1);
        chk_wr("c_wr", 1, 3, 3);

        // wraparound, shifts, chained hazards, then HLT
        clr_mem();
        imem[0] = 16'h81FF; imem[1] = 16'h1111; imem[2] = 16'h8209; imem[3] = 16'h8301;
        imem[6] = 16'h6332; imem[7] = 16'h2023; imem[8] = 16'h7313; imem[9] = 16'h5113;
        imem[10] = 16'hE000; imem[11] = 16'h8207;
        do_reset();
        repeat (40) @(posedge clk); #1;
        chk("d_nwr", 32'(wr_q.size()), 8);
        chk_wr("d_wr", 0, 1, 8'hFF);
        chk_wr("d_wr", 1, 1, 8'hFE);
        chk_wr("d_wr", 2, 2, 9);
        chk_wr("d_wr", 3, 3, 1);
        chk_wr("d_wr", 4, 3, 2);
        chk_wr("d_wr", 5, 0, 7);
        chk_wr("d_wr", 6, 3, 8'h3F);
        chk_wr("d_wr", 7, 1, 8'hC1);
        chk("d_pc30", 32'(pc_log[30]), 11);
        chk("d_pc39", 32'(pc_log[39]), 11);
        chk("d_hlt30", 32'(hlt_log[30]), 1);
        chk("d_hlt39", 32'(hlt_log[39]), 1);
        chk("d_halted", 32'(halted), 1);

        // reset out of HLT clears everything; o_halted asserts one cycle later with i_halt held
        rst = 1'b1;
        hlt = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("r_pc", 32'(pc), 0);
        chk("r_we", 32'(we), 0);
        chk("r_wa", 32'(wa), 0);
        chk("r_wd", 32'(wd), 0);
        chk("r_halted0", 32'(halted), 0);
        @(posedge clk); #1;
        chk("r_halted1", 32'(halted), 1);
        hlt = 1'b0;

        // external stall for cycles 2..6
        clr_mem();
        imem[0] = 16'h8101; imem[1] = 16'h8202; imem[2] = 16'h8303;
        imem[3] = 16'h8104; imem[4] = 16'h8205;
        do_reset();
        repeat (2) @(posedge clk);
        #1 hlt = 1'b1;
        repeat (5) @(posedge clk);
        #1 hlt = 1'b0;
        repeat (15) @(posedge clk); #1;
        chk("e_hlt2", 32'(hlt_log[2]), 0);
        chk("e_hlt3", 32'(hlt_log[3]), 1);
        chk("e_hlt6", 32'(hlt_log[6]), 1);
        chk("e_hlt7", 32'(hlt_log[7]), 0);
        chk("e_pc7", 32'(pc_log[7]), 2);
        chk("e_pc8", 32'(pc_log[8]), 3);
        chk("e_nwr", 32'(wr_q.size()), 5);
        chk_wr("e_wr", 0, 1, 1);
        chk_wr("e_wr", 1, 2, 2);
        chk_wr("e_wr", 2, 3, 3);
        chk_wr("e_wr", 3, 1, 4);
        chk_wr("e_wr", 4, 2, 5);

        // out-of-range registers with NREG=4
        clr_mem();
        imem[0] = 16'h8509; imem[1] = 16'h8107; imem[3] = 16'h9150;
        imem[4] = 16'h8605; imem[5] = 16'h9260;
        do_reset();
        repeat (14) @(posedge clk); #1;
        chk("f_nwr", 32'(wr_q.size()), 5);
        chk_wr("f_wr", 0, 5, 9);
        chk_wr("f_wr", 1, 1, 7);
        chk_wr("f_wr", 2, 1, 0);
        chk_wr("f_wr", 3, 6, 5);
        chk_wr("f_wr", 4, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
